// File: rtl/scrub_scheduler.sv
// scrub_scheduler
// Arbitrates the FPGA configuration port between the frame-readback scrub engine and the
// partial-reconfiguration (DPR) engine. Requests come from SEFI detection (highest priority),
// ground command and an internal periodic timer. Each operation is guarded by a watchdog.
// Failed DPR is retried and escalates to a sticky full-reconfiguration request after
// MAX_RETRY consecutive failures.
//
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   enable         - gate for new grants; an in-flight operation always completes
//   sefi_detected  - SEFI indication (level or pulse)
//   cmd_scrub_req  - ground-commanded scrub pulse
//   scrub_start    - one-cycle start strobe to the scrub engine
//   scrub_done     - scrub completion pulse, qualified by scrub_err
//   dpr_start      - one-cycle start strobe to the DPR engine
//   dpr_done       - DPR success pulse
//   dpr_fail       - DPR failure pulse
//   busy           - not idle
//   escalate       - sticky full-reconfiguration request
//   state_o        - 0=IDLE, 1=SCRUB, 2=DPR, 3=ESCALATED
//   scrub_count    - completed scrubs, saturating
//   fail_count     - DPR failures plus timeouts, saturating
module scrub_scheduler #(
    parameter int unsigned PERIOD_CYCLES  = 50_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter int unsigned MAX_RETRY      = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        sefi_detected,
    input  logic        cmd_scrub_req,
    output logic        scrub_start,
    input  logic        scrub_done,
    input  logic        scrub_err,
    output logic        dpr_start,
    input  logic        dpr_done,
    input  logic        dpr_fail,
    output logic        busy,
    output logic        escalate,
    output logic [1:0]  state_o,
    output logic [15:0] scrub_count,
    output logic [7:0]  fail_count
);

    typedef enum logic [1:0] {
        StIdle      = 2'd0,
        StScrub     = 2'd1,
        StDpr       = 2'd2,
        StEscalated = 2'd3
    } state_e;

    localparam logic [31:0] PeriodLast = 32'(PERIOD_CYCLES - 1);
    localparam logic [23:0] WdogLast   = 24'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  RetryMax   = 4'(MAX_RETRY);

    state_e      state_q;
    logic        sefi_p;
    logic        cmd_p;
    logic        per_p;
    logic [31:0] period_cnt;
    logic [23:0] wdog;
    logic [3:0]  retry_cnt;

    logic        timer_run;
    logic        period_hit;
    logic        wdog_expired;
    logic        dpr_ok;
    logic        dpr_bad;
    logic [3:0]  retry_next;
    logic [15:0] scrub_count_inc;
    logic [7:0]  fail_count_inc;

    always_comb begin
        timer_run       = enable && (state_q != StEscalated);
        period_hit      = (period_cnt == PeriodLast);
        // The watchdog value here is the number of cycles already spent in the state, so
        // this cycle is the TIMEOUT_CYCLES-th one.
        wdog_expired    = (wdog == WdogLast);
        // Fail dominates done; any done/fail pulse dominates the watchdog.
        dpr_ok          = dpr_done && !dpr_fail;
        dpr_bad         = dpr_fail || (wdog_expired && !dpr_done);
        retry_next      = retry_cnt + 4'd1;
        scrub_count_inc = (scrub_count == 16'hFFFF) ? scrub_count : scrub_count + 16'd1;
        fail_count_inc  = (fail_count == 8'hFF) ? fail_count : fail_count + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            sefi_p      <= 1'b0;
            cmd_p       <= 1'b0;
            per_p       <= 1'b0;
            period_cnt  <= 32'd0;
            wdog        <= 24'd0;
            retry_cnt   <= 4'd0;
            scrub_start <= 1'b0;
            dpr_start   <= 1'b0;
            scrub_count <= 16'd0;
            fail_count  <= 8'd0;
        end else begin
            scrub_start <= 1'b0;
            dpr_start   <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (enable) begin
                        if (sefi_p) begin
                            sefi_p    <= 1'b0;
                            dpr_start <= 1'b1;
                            wdog      <= 24'd0;
                            state_q   <= StDpr;
                        end else if (cmd_p || per_p) begin
                            cmd_p       <= 1'b0;
                            per_p       <= 1'b0;
                            scrub_start <= 1'b1;
                            wdog        <= 24'd0;
                            state_q     <= StScrub;
                        end
                    end
                end
                StScrub: begin
                    if (scrub_done) begin
                        scrub_count <= scrub_count_inc;
                        if (scrub_err) begin
                            // Repair straight away; a pending SEFI stays pending.
                            dpr_start <= 1'b1;
                            wdog      <= 24'd0;
                            state_q   <= StDpr;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else if (wdog_expired) begin
                        // A hung scrub engine is treated as a SEFI symptom.
                        fail_count <= fail_count_inc;
                        sefi_p     <= 1'b1;
                        state_q    <= StIdle;
                    end else begin
                        wdog <= wdog + 24'd1;
                    end
                end
                StDpr: begin
                    if (dpr_ok) begin
                        retry_cnt <= 4'd0;
                        state_q   <= StIdle;
                    end else if (dpr_bad) begin
                        fail_count <= fail_count_inc;
                        retry_cnt  <= retry_next;
                        if (retry_next >= RetryMax) begin
                            state_q <= StEscalated;
                        end else begin
                            dpr_start <= 1'b1;
                            wdog      <= 24'd0;
                        end
                    end else begin
                        wdog <= wdog + 24'd1;
                    end
                end
                StEscalated: begin
                    state_q <= StEscalated;
                end
            endcase

            // Request capture comes after the grant so that a request arriving in the
            // grant cycle is not lost.
            if (state_q != StEscalated) begin
                if (sefi_detected) sefi_p <= 1'b1;
                if (cmd_scrub_req) cmd_p <= 1'b1;
            end

            if (timer_run) begin
                if (period_hit) begin
                    period_cnt <= 32'd0;
                    per_p      <= 1'b1;
                end else begin
                    period_cnt <= period_cnt + 32'd1;
                end
            end
        end
    end

    assign busy     = (state_q != StIdle);
    assign escalate = (state_q == StEscalated);
    assign state_o  = state_q;

endmodule

// File: tb/tb_scrub_scheduler.sv
// Testbench for scrub_scheduler: directed scenarios with literal expectations plus a
// per-cycle comparison against a transaction-level model of the scheduling rules.
module tb_scrub_scheduler;

    localparam int P = 100;
    localparam int T = 50;
    localparam int R = 3;

    localparam int MIdle = 0;
    localparam int MScrub = 1;
    localparam int MDpr = 2;
    localparam int MEsc = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        sefi_detected = 1'b0;
    logic        cmd_scrub_req = 1'b0;
    logic        scrub_done = 1'b0;
    logic        scrub_err = 1'b0;
    logic        dpr_done = 1'b0;
    logic        dpr_fail = 1'b0;
    logic        scrub_start;
    logic        dpr_start;
    logic        busy;
    logic        escalate;
    logic [1:0]  state_o;
    logic [15:0] scrub_count;
    logic [7:0]  fail_count;

    int checks = 0;
    int errors = 0;

    scrub_scheduler #(
        .PERIOD_CYCLES (P),
        .TIMEOUT_CYCLES(T),
        .MAX_RETRY     (R)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .sefi_detected(sefi_detected),
        .cmd_scrub_req(cmd_scrub_req),
        .scrub_start  (scrub_start),
        .scrub_done   (scrub_done),
        .scrub_err    (scrub_err),
        .dpr_start    (dpr_start),
        .dpr_done     (dpr_done),
        .dpr_fail     (dpr_fail),
        .busy         (busy),
        .escalate     (escalate),
        .state_o      (state_o),
        .scrub_count  (scrub_count),
        .fail_count   (fail_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: what the scheduler must present after one clock, given the inputs of that cycle.
    typedef struct {
        int mode;
        int sefi;
        int cmd;
        int per;
        int tmr;
        int wd;
        int retry;
        int sc;
        int fc;
        int ss;
        int ds;
    } mstate_t;

    function automatic mstate_t model_step(mstate_t s, bit r, bit en, bit sf, bit cm,
                                           bit sd, bit se, bit dd, bit df);
        mstate_t n;
        int set_sefi;
        int set_per;
        int clr_sefi;
        int clr_scr;
        n = s;
        n.ss = 0;
        n.ds = 0;
        if (r) begin
            n = '{default: 0};
            return n;
        end
        if (s.mode == MEsc) return n;
        set_sefi = int'(sf);
        set_per = 0;
        clr_sefi = 0;
        clr_scr = 0;
        if (en) begin
            if (s.tmr == P - 1) begin
                n.tmr = 0;
                set_per = 1;
            end else begin
                n.tmr = s.tmr + 1;
            end
        end
        case (s.mode)
            MIdle: begin
                if (en && s.sefi != 0) begin
                    n.mode = MDpr; n.ds = 1; n.wd = 0; clr_sefi = 1;
                end else if (en && (s.cmd != 0 || s.per != 0)) begin
                    n.mode = MScrub; n.ss = 1; n.wd = 0; clr_scr = 1;
                end
            end
            MScrub: begin
                if (sd) begin
                    n.sc = (s.sc + 1 > 65535) ? 65535 : s.sc + 1;
                    if (se) begin
                        n.mode = MDpr; n.ds = 1; n.wd = 0;
                    end else begin
                        n.mode = MIdle;
                    end
                end else if (s.wd + 1 == T) begin
                    n.fc = (s.fc + 1 > 255) ? 255 : s.fc + 1;
                    set_sefi = 1;
                    n.mode = MIdle;
                end else begin
                    n.wd = s.wd + 1;
                end
            end
            MDpr: begin
                if (dd && !df) begin
                    n.retry = 0; n.mode = MIdle;
                end else if (df || s.wd + 1 == T) begin
                    n.fc = (s.fc + 1 > 255) ? 255 : s.fc + 1;
                    n.retry = s.retry + 1;
                    if (n.retry == R) n.mode = MEsc;
                    else begin
                        n.ds = 1; n.wd = 0;
                    end
                end else begin
                    n.wd = s.wd + 1;
                end
            end
            default: ;
        endcase
        n.sefi = ((s.sefi != 0 && clr_sefi == 0) || set_sefi != 0) ? 1 : 0;
        n.cmd = ((s.cmd != 0 && clr_scr == 0) || cm) ? 1 : 0;
        n.per = ((s.per != 0 && clr_scr == 0) || set_per != 0) ? 1 : 0;
        return n;
    endfunction

    mstate_t m = '{default: 0};
    bit m_valid = 1'b0;

    always @(posedge clk) begin
        m <= model_step(m, rst, enable, sefi_detected, cmd_scrub_req, scrub_done, scrub_err,
                        dpr_done, dpr_fail);
        if (rst) m_valid <= 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("m_state", int'(state_o), m.mode);
            check("m_busy", int'(busy), (m.mode != MIdle) ? 1 : 0);
            check("m_escalate", int'(escalate), (m.mode == MEsc) ? 1 : 0);
            check("m_scrub_start", int'(scrub_start), m.ss);
            check("m_dpr_start", int'(dpr_start), m.ds);
            check("m_scrub_count", int'(scrub_count), m.sc);
            check("m_fail_count", int'(fail_count), m.fc);
        end
    end

    // Leaves the bench at the negedge of cycle 0, the first cycle after the reset edge.
    task automatic do_reset(input bit en);
        @(negedge clk);
        rst = 1'b1;
        enable = 1'b0;
        sefi_detected = 1'b0;
        cmd_scrub_req = 1'b0;
        scrub_done = 1'b0;
        scrub_err = 1'b0;
        dpr_done = 1'b0;
        dpr_fail = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        enable = en;
        check("reset_state", int'(state_o), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_strobes", int'(scrub_start) + int'(dpr_start), 0);
        check("reset_counts", int'(scrub_count) + int'(fail_count), 0);
    endtask

    initial begin
        int nss;
        int nds;
        int ss_at;
        int ds_at;
        int done_at;
        int st[3];
        int v51;
        int v52;
        int f52;
        int late;

        // 1: periodic scrubs only
        do_reset(1'b1);
        nss = 0;
        done_at = -1;
        for (int c = 1; c <= 320; c++) begin
            @(negedge clk);
            scrub_done = (c == done_at);
            if (scrub_start) begin
                if (nss < 3) st[nss] = c;
                nss++;
                done_at = c + 5;
            end
        end
        scrub_done = 1'b0;
        check("per_n_scrubs", nss, 3);
        check("per_start0", st[0], 101);
        check("per_start1", st[1], 201);
        check("per_start2", st[2], 301);
        check("per_scrub_count", int'(scrub_count), 3);

        // 2: SEFI and command together, SEFI first
        do_reset(1'b1);
        sefi_detected = 1'b1;
        cmd_scrub_req = 1'b1;
        ss_at = -1;
        ds_at = -1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            sefi_detected = 1'b0;
            cmd_scrub_req = 1'b0;
            dpr_done = (c == 5);
            scrub_done = (c == 10);
            if (dpr_start && ds_at < 0) ds_at = c;
            if (scrub_start && ss_at < 0) ss_at = c;
        end
        check("prio_dpr_at", ds_at, 2);
        check("prio_scrub_at", ss_at, 7);
        check("prio_idle", int'(state_o), 0);

        // 3: SEFI held during a scrub is serviced once afterwards
        do_reset(1'b1);
        cmd_scrub_req = 1'b1;
        nss = 0;
        nds = 0;
        ss_at = -1;
        ds_at = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            cmd_scrub_req = 1'b0;
            sefi_detected = (c >= 3 && c <= 12);
            scrub_done = (c == 15);
            dpr_done = (c == 20);
            if (scrub_start) begin nss++; ss_at = c; end
            if (dpr_start) begin nds++; ds_at = c; end
        end
        check("hold_n_scrub", nss, 1);
        check("hold_scrub_at", ss_at, 2);
        check("hold_n_dpr", nds, 1);
        check("hold_dpr_at", ds_at, 17);

        // 4: repeated DPR failure escalates; everything ignored afterwards
        do_reset(1'b1);
        sefi_detected = 1'b1;
        nss = 0;
        nds = 0;
        ds_at = -1;
        for (int c = 1; c <= 250; c++) begin
            @(negedge clk);
            sefi_detected = (c == 30);
            cmd_scrub_req = (c == 20);
            scrub_done = (c == 25);
            dpr_fail = (c == 4 || c == 7 || c == 10);
            if (scrub_start) nss++;
            if (dpr_start) begin nds++; ds_at = c; end
        end
        check("esc_n_dpr", nds, 3);
        check("esc_last_dpr", ds_at, 8);
        check("esc_n_scrub", nss, 0);
        check("esc_state", int'(state_o), 3);
        check("esc_flag", int'(escalate), 1);
        check("esc_busy", int'(busy), 1);
        check("esc_fail_count", int'(fail_count), 3);

        // 5: silent scrub engine times out into a DPR
        do_reset(1'b1);
        cmd_scrub_req = 1'b1;
        ss_at = -1;
        ds_at = -1;
        v51 = -1;
        v52 = -1;
        f52 = -1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            cmd_scrub_req = 1'b0;
            dpr_done = (c == 56);
            if (scrub_start && ss_at < 0) ss_at = c;
            if (dpr_start && ds_at < 0) ds_at = c;
            if (c == 51) v51 = int'(state_o);
            if (c == 52) begin v52 = int'(state_o); f52 = int'(fail_count); end
        end
        check("to_scrub_at", ss_at, 2);
        check("to_state_last", v51, 1);
        check("to_state_exit", v52, 0);
        check("to_fail_count", f52, 1);
        check("to_dpr_at", ds_at, 53);

        // 6: scrub error goes straight to DPR; reset mid-DPR
        do_reset(1'b1);
        cmd_scrub_req = 1'b1;
        ds_at = -1;
        v51 = -1;
        late = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            cmd_scrub_req = 1'b0;
            scrub_done = (c == 4);
            scrub_err = (c == 4);
            rst = (c == 7);
            if (dpr_start && ds_at < 0) ds_at = c;
            if (c == 5) v51 = int'(scrub_count);
            if (c >= 7) late = late + int'(scrub_start) + int'(dpr_start);
            if (c == 8) begin
                check("rst_mid_state", int'(state_o), 0);
                check("rst_mid_flags", int'(busy) + int'(escalate), 0);
                check("rst_mid_counts", int'(scrub_count) + int'(fail_count), 0);
            end
        end
        check("err_dpr_at", ds_at, 5);
        check("err_scrub_count", v51, 1);
        check("rst_mid_no_strobe", late, 0);

        // 7: enable low holds coalesced requests
        do_reset(1'b0);
        cmd_scrub_req = 1'b1;
        nss = 0;
        ss_at = -1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            cmd_scrub_req = (c == 3);
            enable = (c >= 20);
            scrub_done = (c == 23);
            if (scrub_start) begin nss++; if (ss_at < 0) ss_at = c; end
        end
        check("en_scrub_at", ss_at, 21);
        check("en_n_scrub", nss, 1);

        // 8: done beats timeout; done+fail together counts as fail
        do_reset(1'b1);
        sefi_detected = 1'b1;
        nds = 0;
        v51 = -1;
        f52 = -1;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            sefi_detected = (c == 60);
            dpr_done = (c == 51 || c == 64 || c == 67);
            dpr_fail = (c == 64);
            if (dpr_start) nds++;
            if (c == 55) begin v51 = int'(state_o); f52 = int'(fail_count); end
        end
        check("race_state", v51, 0);
        check("race_fail_count", f52, 0);
        check("both_n_dpr", nds, 3);
        check("both_fail_count", int'(fail_count), 1);
        check("both_idle", int'(state_o), 0);

        dpr_done = 1'b0;
        dpr_fail = 1'b0;
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
